// File: rtl/response_uart_pkg.sv
// ============================================================================
//  Module      : response_uart_pkg
//  Description : Shared types and constants for the response UART transmitter.
//                Holds the FSM state enum, the 8N1 frame length, the default
//                baud divider and the number of bytes sent per response.
//                Optional feature macro: RESP_CHECKSUM_EN (adds an XOR
//                checksum byte after the two data bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package response_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS       = 10;
    // 50 MHz / 9600 baud
    localparam int DEFAULT_BAUD_DIV = 5208;

`ifdef RESP_CHECKSUM_EN
    localparam int BYTE_COUNT = 3;
`else
    localparam int BYTE_COUNT = 2;
`endif

    // Byte to transmit for a given position in the response.
    function automatic logic [7:0] select_byte(input logic [15:0] word,
                                               input logic [1:0]  idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
`ifdef RESP_CHECKSUM_EN
            default: return word[7:0] ^ word[15:8];
`else
            default: return word[7:0];
`endif
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period timer. Counts BAUD_DIV-1 down to 0 and reloads,
//                so tick fires once every BAUD_DIV cycles. clear restarts
//                the period so the first bit of a sequence is full length.
//                pre_tick fires one cycle before tick (BAUD_DIV must be >= 2).
//  Ports       : clk, rst_n      - clock, async active-low reset
//                clear           - reload the counter (frame start)
//                tick            - last cycle of the current bit period
//                pre_tick        - second-to-last cycle of the bit period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int            CW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    assign tick     = (count == '0);
    assign pre_tick = (count == CW'(1));

endmodule

`default_nettype wire

// File: rtl/response_uart_tx.sv
// ============================================================================
//  Module      : response_uart_tx
//  Description : Sends a captured 16-bit sensor response as back-to-back 8N1
//                UART frames, low byte first. A bufferPronto level is
//                accepted once per assertion (armed handshake) and
//                acknowledged with a one-cycle bufferUsado pulse.
//                Optional feature macro: RESP_CHECKSUM_EN (third byte =
//                low byte XOR high byte).
//  Ports       : clk, rst_n      - clock, async active-low reset
//                bufferPronto    - response word valid (level)
//                info[15:0]      - response word
//                bufferUsado     - one-cycle capture acknowledge
//                tx              - serial line, idle high
//                busy            - frame sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module response_uart_tx
    import response_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bufferPronto,
    input  logic [15:0] info,
    output logic        bufferUsado,
    output logic        tx,
    output logic        busy
);

    state_t      state;
    logic        armed;
    logic [15:0] captured;
    logic [7:0]  tx_byte;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic        capture;
    logic        tick;
    logic        pre_tick;

    assign capture = (state == IDLE) && bufferPronto && armed;

    // Restarting the timer on capture aligns the first start bit with the
    // cycle after capture; afterwards it free-runs so frames never drift.
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (capture),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b1;
            captured    <= '0;
            tx_byte     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            bufferUsado <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            bufferUsado <= 1'b0;
            // Re-arm only once the controller has dropped bufferPronto.
            if (!bufferPronto) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (capture) begin
                        captured    <= info;
                        tx_byte     <= info[7:0];
                        byte_idx    <= '0;
                        armed       <= 1'b0;
                        bufferUsado <= 1'b1;
                        tx          <= 1'b0;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        tx      <= tx_byte[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= tx_byte[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                // NEXT occupies the final cycle of the stop bit, so the
                // byte-count decision costs no extra line time.
                STOP: begin
                    if (pre_tick) begin
                        state <= NEXT;
                    end
                end

                NEXT: begin
                    if (tick) begin
                        if (byte_idx == 2'(BYTE_COUNT - 1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_byte  <= select_byte(captured, byte_idx + 2'd1);
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_response_uart_tx.sv
// ============================================================================
//  Module      : tb_response_uart_tx
//  Description : Self-checking bench for response_uart_tx. The expected line
//                waveform is derived from the byte list of a response and
//                the 8N1 framing rules; a second instance at the default
//                divider checks real bit lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_response_uart_tx;
    import response_uart_pkg::*;

    localparam int B = 4;
`ifdef RESP_CHECKSUM_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif
    localparam int NCYC = NBYTES * FRAME_BITS * B;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        pronto   = 1'b0;
    logic [15:0] info     = '0;
    logic        usado;
    logic        tx;
    logic        busy;

    logic        pronto_s = 1'b0;
    logic [15:0] info_s   = 16'hFFFF;
    logic        usado_s;
    logic        tx_s;
    logic        busy_s;

    int tests = 0;
    int fails = 0;

    int         obs_usado;
    int         obs_busy;
    int         obs_txerr;
    logic [7:0] obs_bytes [3];

    always #5 clk = ~clk;

    response_uart_tx #(.BAUD_DIV(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bufferPronto (pronto),
        .info         (info),
        .bufferUsado  (usado),
        .tx           (tx),
        .busy         (busy)
    );

    response_uart_tx dut_slow (
        .clk          (clk),
        .rst_n        (rst_n),
        .bufferPronto (pronto_s),
        .info         (info_s),
        .bufferUsado  (usado_s),
        .tx           (tx_s),
        .busy         (busy_s)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_byte(input logic [15:0] v, input int i);
        if (i == 0) return v[7:0];
        if (i == 1) return v[15:8];
        return v[7:0] ^ v[15:8];
    endfunction

    // Expected line level c cycles after the first start bit began.
    function automatic logic model_line(input logic [15:0] v, input int c);
        int k = c / B;
        int pos = k % FRAME_BITS;
        logic [7:0] b = model_byte(v, k / FRAME_BITS);
        if (pos == 0) return 1'b0;
        if (pos == FRAME_BITS - 1) return 1'b1;
        return b[pos-1];
    endfunction

    // ---------------- helpers ----------------
    task automatic wait_usado(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (usado === 1'b1) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_capture: no bufferUsado within 20 cycles", name);
        end
    endtask

    // Watch one full response starting in the bufferUsado cycle.
    task automatic observe(input logic [15:0] v, input int hold,
                           input int raise_at, input logic [15:0] raise_info);
        obs_usado = 0;
        obs_busy  = 0;
        obs_txerr = 0;
        for (int i = 0; i < 3; i++) obs_bytes[i] = '0;
        for (int c = 0; c < NCYC; c++) begin
            if (usado === 1'b1) obs_usado++;
            if (busy === 1'b1) obs_busy++;
            if (tx !== model_line(v, c)) obs_txerr++;
            if (c % B == B / 2) begin
                int k = c / B;
                int pos = k % FRAME_BITS;
                if (pos >= 1 && pos <= 8) obs_bytes[k / FRAME_BITS][pos-1] = tx;
            end
            if (c == hold) pronto = 1'b0;
            if (c == raise_at) begin
                info   = raise_info;
                pronto = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_observe(input string name, input logic [15:0] v);
        tests++;
        if (obs_usado !== 1) begin
            fails++;
            $display("FAIL %s_usado_pulses: got %0d expected 1", name, obs_usado);
        end
        tests++;
        if (obs_busy !== NCYC) begin
            fails++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, obs_busy, NCYC);
        end
        tests++;
        if (obs_txerr !== 0) begin
            fails++;
            $display("FAIL %s_tx_wave: %0d cycles differ, expected 0", name, obs_txerr);
        end
        for (int i = 0; i < NBYTES; i++) begin
            tests++;
            if (obs_bytes[i] !== model_byte(v, i)) begin
                fails++;
                $display("FAIL %s_byte%0d: got %02h expected %02h",
                         name, i, obs_bytes[i], model_byte(v, i));
            end
        end
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL %s_end_idle: busy=%b tx=%b expected busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic quiet_check(input string name, input int ncyc);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || usado !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d non-idle cycles, expected 0", name, bad);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++;
        if (usado !== 1'b0) begin fails++; $display("FAIL reset_usado: got %b expected 0", usado); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        pronto = 1'b0;
        quiet_check("idle_1000", 1000);
    endtask

    task automatic run_one(input string name, input logic [15:0] v, input int hold);
        bit ok;
        @(negedge clk);
        info   = v;
        pronto = 1'b1;
        wait_usado(name, ok);
        if (ok) begin
            observe(v, hold, -1, 16'h0);
            check_observe(name, v);
        end
        pronto = 1'b0;
    endtask

    task automatic test_single();
        run_one("single_5A63", 16'h5A63, 3);
        quiet_check("single_no_repeat", 3 * NCYC);
    endtask

    task automatic test_fixed_words();
        run_one("word_1234", 16'h1234, 0);
        run_one("word_0000", 16'h0000, 1);
        run_one("word_FFFF", 16'hFFFF, 2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [15:0] v = 16'($urandom);
            int hold = int'($urandom_range(0, 6));
            run_one($sformatf("random%0d", n), v, hold);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] first = 16'($urandom);
        @(negedge clk);
        info   = first;
        pronto = 1'b1;
        wait_usado("b2b_first", ok);
        if (ok) begin
            observe(first, 0, 10, 16'h0001);
            check_observe("b2b_first", first);
            tests++;
            if (usado !== 1'b0) begin
                fails++;
                $display("FAIL b2b_gap_usado: got %b expected 0", usado);
            end
            @(negedge clk);
            tests++;
            if (usado !== 1'b1 || tx !== 1'b0) begin
                fails++;
                $display("FAIL b2b_second_capture: usado=%b tx=%b expected usado=1 tx=0", usado, tx);
            end
            observe(16'h0001, 0, -1, 16'h0);
            check_observe("b2b_second", 16'h0001);
        end
        pronto = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        @(negedge clk);
        info   = 16'h5A63;
        pronto = 1'b1;
        wait_usado("rstmid", ok);
        pronto = 1'b0;
        if (ok) begin
            // middle of data bit 3 of byte 0 (0x63 bit 3 is 0)
            repeat (4 * B + B / 2) @(negedge clk);
            tests++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL rstmid_before: tx=%b busy=%b expected tx=0 busy=1", tx, busy);
            end
            rst_n = 1'b0;
            #1;
            tests++;
            if (tx !== 1'b1 || busy !== 1'b0 || usado !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_async: tx=%b busy=%b usado=%b expected 1 0 0", tx, busy, usado);
            end
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            quiet_check("rstmid_no_residual", 100);
        end
    endtask

    task automatic test_reset_release_capture();
        bit ok;
        logic [15:0] v = 16'($urandom);
        @(negedge clk);
        rst_n  = 1'b0;
        info   = v;
        pronto = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ok = (usado === 1'b1);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL release_first_edge: usado=%b expected 1", usado);
        end else begin
            observe(v, 0, -1, 16'h0);
            check_observe("release", v);
        end
        pronto = 1'b0;
    endtask

    task automatic test_slow_bit_timing();
        bit ok = 1'b0;
        int lo = 0;
        int hi = 0;
        int lo2 = 0;
        @(negedge clk);
        pronto_s = 1'b1;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (usado_s === 1'b1) ok = 1'b1;
        end
        pronto_s = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL slow_capture: no bufferUsado within 5 cycles");
        end else begin
            while (tx_s === 1'b0 && lo < 6000) begin lo++; @(negedge clk); end
            while (tx_s === 1'b1 && hi < 50000) begin hi++; @(negedge clk); end
            while (tx_s === 1'b0 && lo2 < 6000) begin lo2++; @(negedge clk); end
            tests++;
            if (lo != 5208) begin
                fails++;
                $display("FAIL slow_start_bit: got %0d cycles expected 5208", lo);
            end
            tests++;
            if (hi != 9 * 5208) begin
                fails++;
                $display("FAIL slow_data_stop_run: got %0d cycles expected %0d", hi, 9 * 5208);
            end
            tests++;
            if (lo2 != 5208) begin
                fails++;
                $display("FAIL slow_second_start: got %0d cycles expected 5208", lo2);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_fixed_words();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_release_capture();
        test_slow_bit_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
